// File: rtl/cla_seq_adder_ctrl_pkg.sv
// cla_seq_adder_ctrl_pkg: shared state encodings and operation codes for the sequential adder
package cla_seq_adder_ctrl_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// cla_seq_adder_ctrl_if: issue-side and writeback-side handshakes of the sequential adder
interface cla_seq_adder_ctrl_if #(parameter int WIDTH = 64);
  logic in_valid, in_ready, op_sub, flush;
  logic out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;
  modport master(output in_valid, op_sub, a, b, flush, out_ready,
                 input in_ready, out_valid, sum, cout, ovf);
  modport slave(input in_valid, op_sub, a, b, flush, out_ready,
                output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/cla_seq_adder_ctrl_slice.sv
// cla_seq_adder_ctrl_slice: combinational SLICE-bit adder built from 4-bit lookahead groups
module cla_seq_adder_ctrl_slice #(parameter int SLICE = 16) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);
  localparam int NG = SLICE / 4;
  logic [SLICE-1:0] g, p, c;
  logic [NG:0] gc;
  assign g = a & b;
  assign p = a ^ b;
  assign gc[0] = cin;
  for (genvar k = 0; k < NG; k++) begin : grp
    logic [3:0] gg, pp;
    assign gg = g[4*k +: 4];
    assign pp = p[4*k +: 4];
    assign c[4*k]   = gc[k];
    assign c[4*k+1] = gg[0] | (pp[0] & gc[k]);
    assign c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gc[k]);
    assign c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & gc[k]);
    // group carry-out from group generate/propagate, chained across groups
    assign gc[k+1]  = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & gc[k]);
  end
  assign s = p ^ c;
  assign cout = gc[NG];
endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: wide add/subtract sequenced over one narrow lookahead slice, one op in flight
module cla_seq_adder_ctrl
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input logic clock,
  input logic reset_n,
  cla_seq_adder_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  logic [1:0] state;
  logic [WIDTH-1:0] a_reg, b_reg, sum_r, b_eff;
  logic [IW-1:0] idx;
  logic carry, cout_r, ovf_r, sa, sb, c, last;
  logic [SLICE-1:0] s;
  cla_seq_adder_ctrl_slice #(.SLICE(SLICE)) u_slice (
    .a(a_reg[SLICE-1:0]), .b(b_reg[SLICE-1:0]), .cin(carry), .s(s), .cout(c)
  );
  assign b_eff = bus.op_sub == OP_ADD ? bus.b : ~bus.b;
  assign last = idx == IW'(NSLICE - 1);
  assign bus.in_ready = state == ST_IDLE;
  assign bus.out_valid = state == ST_DONE;
  assign bus.sum = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf = ovf_r;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      idx <= '0;
      cout_r <= 1'b0;
      ovf_r <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
    end else if (bus.flush) begin
      state <= ST_IDLE;
    end else if (state == ST_IDLE) begin
      if (bus.in_valid) begin
        a_reg <= bus.a;
        b_reg <= b_eff;
        carry <= bus.op_sub == OP_SUB;
        idx <= '0;
        sa <= bus.a[WIDTH-1];
        sb <= b_eff[WIDTH-1];
        state <= ST_RUN;
      end
    end else if (state == ST_RUN) begin
      sum_r[idx*SLICE +: SLICE] <= s;
      carry <= c;
      a_reg <= a_reg >> SLICE;
      b_reg <= b_reg >> SLICE;
      idx <= last ? '0 : idx + 1'b1;
      if (last) begin
        cout_r <= c;
        ovf_r <= (sa == sb) && (s[SLICE-1] != sa);
        state <= ST_DONE;
      end
    end else if (state == ST_DONE) begin
      if (bus.out_ready) state <= ST_IDLE;
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb_cla_seq_adder_ctrl: scoreboard bench for the sequential lookahead adder (WIDTH=64, SLICE=16)
module tb_cla_seq_adder_ctrl;
  localparam int W = 64;
  typedef struct packed {logic [W-1:0] s; logic c; logic v;} res_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  res_t sb_q[$];
  int n_vec = 0;
  int n_bad = 0;
  always #5 clock = ~clock;
  cla_seq_adder_ctrl_if #(.WIDTH(W)) bus();
  cla_seq_adder_ctrl #(.WIDTH(W), .SLICE(16)) dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic push_exp(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    res_t e;
    r = sub ? {1'b0, a} + {1'b0, ~b} + 65'd1 : {1'b0, a} + {1'b0, b};
    e.s = r[W-1:0];
    e.c = r[W];
    e.v = sub ? (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]) : (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    sb_q.push_back(e);
  endtask
  task automatic issue(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    int n = 0;
    while (!bus.in_ready && n < 20) begin step(); n++; end
    check("in_ready_wait", W'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.op_sub = sub;
    bus.a = a;
    bus.b = b;
    if (keep) push_exp(sub, a, b);
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic collect(input int hold);
    int n = 0;
    res_t e;
    while (!bus.out_valid && n < 20) begin step(); n++; end
    check("latency", W'(n), 4);
    check("sb_nonempty", W'(sb_q.size() > 0), 1);
    e = sb_q.size() > 0 ? sb_q.pop_front() : '0;
    check("sum", bus.sum, e.s);
    check("cout", W'(bus.cout), W'(e.c));
    check("ovf", W'(bus.ovf), W'(e.v));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      bus.a = W'($urandom);
      step();
      check("hold_valid", W'(bus.out_valid), 1);
      check("hold_in_ready", W'(bus.in_ready), 0);
      check("hold_sum", bus.sum, e.s);
      check("hold_cout", W'(bus.cout), W'(e.c));
      check("hold_ovf", W'(bus.ovf), W'(e.v));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("take_in_ready", W'(bus.in_ready), 0);
    step();
    bus.out_ready = 1'b0;
    check("after_take_in_ready", W'(bus.in_ready), 1);
    check("after_take_out_valid", W'(bus.out_valid), 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.op_sub = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    check("rst_in_ready", W'(bus.in_ready), 1);
    check("rst_out_valid", W'(bus.out_valid), 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", W'(bus.cout), 0);
    check("rst_ovf", W'(bus.ovf), 0);
    reset_n = 1'b1;
    step();
    issue(0, 64'h0000_0000_0000_FFFF, 64'd1, 1); collect(0);
    issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1); collect(0);
    issue(1, 64'd5, 64'd7, 1); collect(0);
    issue(1, 64'd7, 64'd5, 1); collect(0);
    issue(1, 64'h8000_0000_0000_0000, 64'd1, 1); collect(0);
    issue(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1); collect(0);
    issue(0, 64'hDEAD_BEEF_0123_4567, 64'h1234_5678_9ABC_DEF0, 1); collect(10);
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    check("flush_vs_accept_idle", W'(bus.in_ready), 1);
    step();
    check("flush_vs_accept_novalid", W'(bus.out_valid), 0);
    issue(0, 64'h1111, 64'h2222, 0);
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_idle", W'(bus.in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("flush_no_valid", W'(bus.out_valid), 0);
    end
    issue(0, 64'h3333, 64'h4444, 0);
    step();
    reset_n = 1'b0;
    #1;
    check("rst_mid_idle", W'(bus.in_ready), 1);
    check("rst_mid_no_valid", W'(bus.out_valid), 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rst_mid_no_valid_after", W'(bus.out_valid), 0);
    end
    issue(0, 64'd3, 64'd4, 1); collect(0);
    for (int i = 0; i < 8; i++) begin
      issue(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1);
      collect(0);
    end
    check("sb_empty", W'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
